// File: rtl/mult_float_arbiter_if.sv
// Request/response bundle between the float datapath clients and the shared
// multiplier arbiter. Operands are packed 32 bits per requester, index 0 lowest.
interface mult_float_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int COUNT_W = 16
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic [31:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_ready;
  logic                  busy;
  logic [COUNT_W-1:0]    op_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy, op_count
  );
endinterface

// File: rtl/mult_float_arbiter.sv
// Shared single-precision multiplier with a round-robin front end.
// One multiply in flight: IDLE grants, MUL registers the product, RESP holds it
// until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a request; grants the next valid requester round-robin
// MUL   | latched operands drive the multiplier; product registered at the edge
// RESP  | result presented until rsp_ready, then back to IDLE

module mult_32bits_float (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);
  logic        sign;
  logic [47:0] ma, mb, prod;
  logic [23:0] mant;
  logic        guard, sticky;
  logic [24:0] mant_r;
  logic [9:0]  exp_s, exp_r;
  logic [22:0] frac;

  // Normals only: zero/denormal inputs give signed zero, Inf/NaN inputs give
  // signed Inf; the mantissa product is rounded to nearest-even.
  always_comb begin
    sign = a_i[31] ^ b_i[31];
    ma   = {24'd0, 1'b1, a_i[22:0]};
    mb   = {24'd0, 1'b1, b_i[22:0]};
    prod = ma * mb;
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_s  = {2'b00, a_i[30:23]} + {2'b00, b_i[30:23]} - 10'd126;
    end else begin
      mant   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      exp_s  = {2'b00, a_i[30:23]} + {2'b00, b_i[30:23]} - 10'd127;
    end
    mant_r = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    exp_r  = mant_r[24] ? exp_s + 10'd1 : exp_s;
    frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    if (a_i[30:23] == 8'd0 || b_i[30:23] == 8'd0) begin
      p_o = {sign, 31'd0};
    end else if (a_i[30:23] == 8'hFF || b_i[30:23] == 8'hFF) begin
      p_o = {sign, 8'hFF, 23'd0};
    end else if (exp_r[9] || exp_r == 10'd0) begin
      p_o = {sign, 31'd0};
    end else if (exp_r >= 10'd255) begin
      p_o = {sign, 8'hFF, 23'd0};
    end else begin
      p_o = {sign, exp_r[7:0], frac};
    end
  end
endmodule

module mult_float_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int COUNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  mult_float_arbiter_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [ID_W-1:0]    op_id_q, op_id_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [31:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [COUNT_W-1:0] op_count_q, op_count_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx, cand;
  logic [31:0]        sel_a, sel_b, product;

  // Round-robin search starting just after the last winner; wraps to itself.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = bus.req_a[32*i +: 32];
        sel_b = bus.req_b[32*i +: 32];
      end
    end
  end

  mult_32bits_float u_mul (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (product)
  );

  // Next-state and handshake logic.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    op_id_d       = op_id_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    rsp_data_d    = rsp_data_q;
    rsp_id_d      = rsp_id_q;
    rsp_valid_d   = rsp_valid_q;
    op_count_d    = op_count_q;
    bus.req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          bus.req_ready[grant_idx] = 1'b1;
          op_a_d       = sel_a;
          op_b_d       = sel_b;
          op_id_d      = grant_idx;
          last_grant_d = grant_idx;
          state_d      = MUL;
        end
      end
      MUL: begin
        rsp_data_d  = product;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + COUNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      op_id_q      <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_id_q      <= op_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_mult_float_arbiter.sv
// Bench for mult_float_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model (real-arithmetic products).
module tb_mult_float_arbiter;
  localparam int NR = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  int   m_last = NR - 1;
  int   m_count = 0;

  always #5 clk = ~clk;

  mult_float_arbiter_if #(.NUM_REQ(NR), .ID_W(2), .COUNT_W(CW)) bus ();

  mult_float_arbiter #(.NUM_REQ(NR), .ID_W(2), .COUNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    real         ma, mb, r;
    logic [63:0] d;
    int          e;
    logic [22:0] frac;
    logic [28:0] rem;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    ma = 1.0 + real'(a[22:0]) / 8388608.0;
    mb = 1.0 + real'(b[22:0]) / 8388608.0;
    r  = ma * mb * (2.0 ** real'(int'(a[30:23]) + int'(b[30:23]) - 254));
    d  = $realtobits(r);
    e  = int'(d[62:52]) - 1023 + 127;
    frac = d[51:29];
    rem  = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && frac[0])) begin
      if (frac == 23'h7F_FFFF) begin
        frac = '0;
        e++;
      end else begin
        frac = frac + 23'd1;
      end
    end
    return {s, 8'(e), frac};
  endfunction

  function automatic logic [31:0] rnd_op();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic test_reset();
    @(posedge clk);
    #2;
    n_total++; if (bus.req_ready !== 4'b0) $display("FAIL rst_ready got=%b exp=0000", bus.req_ready); else n_pass++;
    n_total++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.op_count !== 4'd0) $display("FAIL rst_op_count got=%0d exp=0", bus.op_count); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else n_pass++;
    rst = 1'b0;
    next_cyc();
    bus.req_valid = 4'b0001;
    bus.req_a[31:0] = 32'h3F80_0000;
    bus.req_b[31:0] = 32'h3F80_0000;
    bus.rsp_ready = 1'b0;
    next_cyc();
    bus.req_valid = 4'b0000;
    next_cyc();
    #2;
    n_total++; if (bus.rsp_valid !== 1'b1) $display("FAIL rst_pre_rsp got=%b exp=1", bus.rsp_valid); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_mid_rsp_valid got=%b exp=0", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.rsp_data !== 32'h0) $display("FAIL rst_mid_rsp_data got=%h exp=0", bus.rsp_data); else n_pass++;
    n_total++; if (bus.rsp_id !== 2'd0) $display("FAIL rst_mid_rsp_id got=%0d exp=0", bus.rsp_id); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); else n_pass++;
    rst = 1'b0;
    m_last = NR - 1;
    m_count = 0;
  endtask

  task automatic test_single_op();
    next_cyc();
    bus.req_valid = 4'b0001;
    bus.req_a[31:0] = 32'h4000_0000;
    bus.req_b[31:0] = 32'h4040_0000;
    bus.rsp_ready = 1'b1;
    #2;
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL single_ready got=%b exp=0001", bus.req_ready); else n_pass++;
    next_cyc();
    bus.req_valid = 4'b0000;
    #2;
    n_total++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) $display("FAIL single_mul got v=%b busy=%b exp v=0 busy=1", bus.rsp_valid, bus.busy); else n_pass++;
    next_cyc();
    #2;
    n_total++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_rsp_valid got=%b exp=1", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.rsp_data !== 32'h40C0_0000) $display("FAIL single_rsp_data got=%h exp=40c00000", bus.rsp_data); else n_pass++;
    n_total++; if (bus.rsp_id !== 2'd0) $display("FAIL single_rsp_id got=%0d exp=0", bus.rsp_id); else n_pass++;
    next_cyc();
    #2;
    m_count++;
    m_last = 0;
    n_total++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) $display("FAIL single_idle got busy=%b v=%b exp 0 0", bus.busy, bus.rsp_valid); else n_pass++;
    n_total++; if (bus.op_count !== 4'(m_count)) $display("FAIL single_count got=%0d exp=%0d", bus.op_count, m_count % 16); else n_pass++;
  endtask

  task automatic test_fairness();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m_last = NR - 1;
    m_count = 0;
    for (int i = 0; i < NR; i++) begin
      bus.req_a[32*i +: 32] = 32'hC000_0000;
      bus.req_b[32*i +: 32] = 32'h3F00_0000;
    end
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      next_cyc();
      bus.req_valid = 4'b1111;
      #2;
      if (k % 3 == 0) begin
        n_total++; if (bus.req_ready !== 4'(1 << ((k / 3) % NR))) $display("FAIL fair_grant k=%0d got=%b exp_id=%0d", k, bus.req_ready, (k / 3) % NR); else n_pass++;
        n_total++; if (bus.op_count !== 4'(k / 3)) $display("FAIL fair_count k=%0d got=%0d exp=%0d", k, bus.op_count, k / 3); else n_pass++;
      end else begin
        n_total++; if (bus.req_ready !== 4'b0) $display("FAIL fair_noready k=%0d got=%b exp=0000", k, bus.req_ready); else n_pass++;
      end
      if (k % 3 == 2) begin
        n_total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hBF80_0000) $display("FAIL fair_rsp k=%0d got v=%b d=%h exp v=1 d=bf800000", k, bus.rsp_valid, bus.rsp_data); else n_pass++;
        n_total++; if (bus.rsp_id !== 2'((k / 3) % NR)) $display("FAIL fair_rsp_id k=%0d got=%0d exp=%0d", k, bus.rsp_id, (k / 3) % NR); else n_pass++;
      end
    end
    next_cyc();
    bus.req_valid = 4'b0000;
    #2;
    m_count = 5;
    m_last = 0;
    n_total++; if (bus.op_count !== 4'(m_count) || bus.busy !== 1'b0) $display("FAIL fair_end got cnt=%0d busy=%b exp cnt=5 busy=0", bus.op_count, bus.busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    next_cyc();
    bus.req_valid = 4'b0010;
    bus.req_a[63:32] = 32'h3FC0_0000;
    bus.req_b[63:32] = 32'h4000_0000;
    bus.rsp_ready = 1'b0;
    #2;
    n_total++; if (bus.req_ready !== 4'b0010) $display("FAIL bp_grant got=%b exp=0010", bus.req_ready); else n_pass++;
    next_cyc();
    bus.req_valid = 4'b0000;
    next_cyc();
    for (int j = 0; j < 5; j++) begin
      bus.req_valid = (j % 2 == 0) ? 4'b1111 : 4'b0101;
      #2;
      n_total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h4040_0000 || bus.rsp_id !== 2'd1)
        $display("FAIL bp_hold j=%0d got v=%b d=%h id=%0d exp v=1 d=40400000 id=1", j, bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      else n_pass++;
      n_total++; if (bus.req_ready !== 4'b0) $display("FAIL bp_noready j=%0d got=%b exp=0000", j, bus.req_ready); else n_pass++;
      next_cyc();
    end
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b1;
    next_cyc();
    #2;
    m_count++;
    m_last = 1;
    n_total++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) $display("FAIL bp_release got busy=%b v=%b exp 0 0", bus.busy, bus.rsp_valid); else n_pass++;
    n_total++; if (bus.op_count !== 4'(m_count)) $display("FAIL bp_count got=%0d exp=%0d", bus.op_count, m_count % 16); else n_pass++;
  endtask

  task automatic test_reset_in_mul();
    next_cyc();
    bus.req_valid = 4'b0100;
    bus.req_a[95:64] = 32'h4080_0000;
    bus.req_b[95:64] = 32'h4080_0000;
    bus.rsp_ready = 1'b1;
    #2;
    n_total++; if (bus.req_ready !== 4'b0100) $display("FAIL rmul_grant got=%b exp=0100", bus.req_ready); else n_pass++;
    next_cyc();
    bus.req_valid = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) $display("FAIL rmul_drop got busy=%b v=%b exp 0 0", bus.busy, bus.rsp_valid); else n_pass++;
    rst = 1'b0;
    m_last = NR - 1;
    m_count = 0;
    #1;
    bus.req_valid = 4'b0101;
    bus.req_a[31:0] = 32'h3F80_0000;
    bus.req_b[31:0] = 32'h4000_0000;
    #1;
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL rmul_prio got=%b exp=0001", bus.req_ready); else n_pass++;
    next_cyc();
    bus.req_valid = 4'b0100;
    next_cyc();
    #2;
    n_total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 32'h4000_0000)
      $display("FAIL rmul_rsp0 got v=%b id=%0d d=%h exp v=1 id=0 d=40000000", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    else n_pass++;
    next_cyc();
    #2;
    n_total++; if (bus.req_ready !== 4'b0100 || bus.op_count !== 4'd1) $display("FAIL rmul_next got rdy=%b cnt=%0d exp rdy=0100 cnt=1", bus.req_ready, bus.op_count); else n_pass++;
    next_cyc();
    bus.req_valid = 4'b0000;
    next_cyc();
    #2;
    n_total++; if (bus.rsp_id !== 2'd2 || bus.rsp_data !== 32'h4180_0000) $display("FAIL rmul_rsp2 got id=%0d d=%h exp id=2 d=41800000", bus.rsp_id, bus.rsp_data); else n_pass++;
    next_cyc();
    m_count = 2;
    m_last = 2;
  endtask

  task automatic test_counter_wrap();
    bus.req_a[127:96] = 32'h3F80_0000;
    bus.req_b[127:96] = 32'h3F80_0000;
    bus.rsp_ready = 1'b1;
    while (m_count < 17) begin
      next_cyc();
      bus.req_valid = 4'b1000;
      #2;
      n_total++; if (bus.req_ready !== 4'b1000) $display("FAIL wrap_grant n=%0d got=%b exp=1000", m_count, bus.req_ready); else n_pass++;
      next_cyc();
      bus.req_valid = 4'b0000;
      next_cyc();
      #2;
      n_total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3) $display("FAIL wrap_rsp n=%0d got v=%b id=%0d exp v=1 id=3", m_count, bus.rsp_valid, bus.rsp_id); else n_pass++;
      next_cyc();
      #2;
      m_count++;
      n_total++; if (bus.op_count !== 4'(m_count % 16)) $display("FAIL wrap_count n=%0d got=%0d exp=%0d", m_count, bus.op_count, m_count % 16); else n_pass++;
    end
    m_last = 3;
  endtask

  task automatic test_random();
    logic [NR-1:0] r_valid;
    logic [31:0]   r_a [NR];
    logic [31:0]   r_b [NR];
    logic [NR-1:0] exp_rdy;
    logic [31:0]   p_data;
    bit            p;
    bit            found;
    bit            exp_rv;
    int            p_gc, p_id, g, idx;
    r_valid = '0;
    p = 1'b0;
    p_gc = 0;
    p_id = 0;
    p_data = '0;
    for (int i = 0; i < NR; i++) begin
      r_a[i] = '0;
      r_b[i] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      next_cyc();
      for (int i = 0; i < NR; i++) begin
        if (!r_valid[i]) begin
          if ($urandom_range(0, 99) < 35) begin
            r_valid[i] = 1'b1;
            r_a[i] = rnd_op();
            r_b[i] = rnd_op();
          end
        end else if ($urandom_range(0, 99) < 8) begin
          r_valid[i] = 1'b0;
        end
        bus.req_a[32*i +: 32] = r_a[i];
        bus.req_b[32*i +: 32] = r_b[i];
      end
      bus.req_valid = r_valid;
      bus.rsp_ready = ($urandom_range(0, 99) < 60);
      #2;
      exp_rv = p && (cyc >= p_gc + 2);
      found = 1'b0;
      g = 0;
      if (!p) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (m_last + k) % NR;
          if (!found && r_valid[idx]) begin
            found = 1'b1;
            g = idx;
          end
        end
      end
      exp_rdy = found ? 4'(1 << g) : 4'b0;
      n_total++; if (bus.req_ready !== exp_rdy) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy); else n_pass++;
      n_total++; if (bus.busy !== p) $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, p); else n_pass++;
      n_total++; if (bus.rsp_valid !== exp_rv) $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_rv); else n_pass++;
      if (exp_rv) begin
        n_total++; if (bus.rsp_data !== p_data || bus.rsp_id !== 2'(p_id))
          $display("FAIL rnd_rsp cyc=%0d got d=%h id=%0d exp d=%h id=%0d", cyc, bus.rsp_data, bus.rsp_id, p_data, p_id);
        else n_pass++;
      end
      n_total++; if (bus.op_count !== 4'(m_count % 16)) $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, bus.op_count, m_count % 16); else n_pass++;
      if (found) begin
        p = 1'b1;
        p_gc = cyc;
        p_id = g;
        p_data = fmul_ref(r_a[g], r_b[g]);
        m_last = g;
        r_valid[g] = 1'b0;
      end else if (exp_rv && bus.rsp_ready) begin
        p = 1'b0;
        m_count++;
      end
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_fairness();
    test_backpressure();
    test_reset_in_mul();
    test_counter_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end
endmodule
